// File: rtl/reg_wb_if.sv
// -----------------------------------------------------------------------------
// reg_wb_if
//   Bundles the writeback handshakes, the issue/hazard-check signals and the
//   register bank write outputs of reg_wb_arbiter.
//   master : upstream side (drives requests, issue and source indices)
//   slave  : arbiter side (drives READYs, busy flags, bank write, PENDING)
//   Signals:
//     a_valid/a_ready/a_reg/a_data   ALU writeback request and grant
//     b_valid/b_ready/b_reg/b_data   load writeback request and grant
//     issue_en/issue_reg             destination of the issuing instruction
//     rs1/rs2, rs1_busy/rs2_busy     hazard lookup
//     reg_write/write_register/write_data  register bank write port
//     pending                        outstanding-write scoreboard
// -----------------------------------------------------------------------------
interface reg_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int NREG = 2 ** ADDR_W;

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;

    logic              issue_en;
    logic [ADDR_W-1:0] issue_reg;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              rs1_busy;
    logic              rs2_busy;

    logic              reg_write;
    logic [ADDR_W-1:0] write_register;
    logic [DATA_W-1:0] write_data;
    logic [NREG-1:0]   pending;

    modport master (
        output a_valid, a_reg, a_data,
        output b_valid, b_reg, b_data,
        output issue_en, issue_reg, rs1, rs2,
        input  a_ready, b_ready, rs1_busy, rs2_busy,
        input  reg_write, write_register, write_data, pending
    );

    modport slave (
        input  a_valid, a_reg, a_data,
        input  b_valid, b_reg, b_data,
        input  issue_en, issue_reg, rs1, rs2,
        output a_ready, b_ready, rs1_busy, rs2_busy,
        output reg_write, write_register, write_data, pending
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// -----------------------------------------------------------------------------
// reg_wb_arbiter
//   Shares the single register bank write port between the ALU (A) and load
//   (B) writeback paths with round-robin arbitration, a one-cycle registered
//   write stage, and a pending-write scoreboard for RS1/RS2 hazard checks.
//   Ports:
//     i_clk    rising-edge clock
//     i_rst_n  asynchronous active-low reset
//     bus      reg_wb_if.slave: requests/grants, issue, hazard lookup,
//              bank write outputs and scoreboard
// -----------------------------------------------------------------------------
module reg_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    reg_wb_if.slave  bus
);
    localparam int NREG = 2 ** ADDR_W;

    // r_prio_b = 1 means B wins the next contended cycle
    logic              r_prio_b;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic [NREG-1:0]   r_pending;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_accept;
    logic [ADDR_W-1:0] w_acc_reg;
    logic [DATA_W-1:0] w_acc_data;
    logic [NREG-1:0]   w_clr_mask;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_pending_nxt;

    // A grant always implies the matching VALID, so grant == accept this edge
    assign w_grant_a = bus.a_valid & (~bus.b_valid | ~r_prio_b);
    assign w_grant_b = bus.b_valid & (~bus.a_valid |  r_prio_b);
    assign w_accept  = w_grant_a | w_grant_b;

    assign w_acc_reg  = w_grant_b ? bus.b_reg  : bus.a_reg;
    assign w_acc_data = w_grant_b ? bus.b_data : bus.a_data;

    // Set is applied after clear so a new producer issuing in the same cycle
    // as the old producer's writeback keeps the register marked busy.
    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (w_accept) begin
            w_clr_mask[w_acc_reg] = 1'b1;
        end
        if (bus.issue_en && (bus.issue_reg != '0)) begin
            w_set_mask[bus.issue_reg] = 1'b1;
        end
    end

    assign w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio_b     <= 1'b0;
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_pending    <= '0;
        end else begin
            if (w_accept) begin
                r_prio_b     <= w_grant_a;
                r_write_reg  <= w_acc_reg;
                r_write_data <= w_acc_data;
            end
            // r0 is hardwired zero: the accept still happens, the bank write does not
            r_reg_write <= w_accept && (w_acc_reg != '0);
            r_pending   <= w_pending_nxt;
        end
    end

    assign bus.a_ready        = w_grant_a;
    assign bus.b_ready        = w_grant_b;
    assign bus.rs1_busy       = r_pending[bus.rs1] & (bus.rs1 != '0);
    assign bus.rs2_busy       = r_pending[bus.rs2] & (bus.rs2 != '0);
    assign bus.reg_write      = r_reg_write;
    assign bus.write_register = r_write_reg;
    assign bus.write_data     = r_write_data;
    assign bus.pending        = r_pending;
endmodule
